// File: rtl/id_ex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_ctrl_pipe
//
// Decodes the 4-bit WISC opcode sitting in ID, registers the resulting control
// bundle into the ID/EX pipeline register together with a valid bit and the
// destination register, detects load-use hazards against the instruction in
// EX, and sequences an HLT through a fixed pipeline drain to a sticky halt.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   id_valid   in   IF/ID holds a real instruction
//   opcode     in   instr[15:12]
//   id_rd      in   destination field
//   id_rs      in   source-1 field
//   id_rt      in   source-2 field
//   ext_stall  in   downstream busy, freeze the EX register
//   flush      in   taken branch, squash the instruction in ID
//   id_stall   out  hold PC and IF/ID this cycle (combinational)
//   ex_valid   out  EX holds a real instruction
//   ex_ctrl    out  {WriteReg, ALU2Mux, addrCalc, loadByteMux, DstMux,
//                    enableMem, readWriteMem, Zen, Ven, Nen}, bit 9 = WriteReg
//   ex_rd      out  registered destination
//   halted     out  sticky halt
// ---------------------------------------------------------------------------
module id_ex_ctrl_pipe #(
    parameter int REG_W       = 4,
    parameter int HLT_DRAIN   = 3,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       opcode,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [9:0]       ex_ctrl,
    output logic [REG_W-1:0] ex_rd,
    output logic             halted
);

    localparam int              CNT_W     = (HLT_DRAIN < 1) ? 1 : $clog2(HLT_DRAIN + 1);
    localparam logic [CNT_W-1:0] DRAIN_TGT = CNT_W'(HLT_DRAIN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]      OP_HLT    = 4'hF;
    localparam int              DST_BIT   = 5;

    logic [9:0]       idCtrl;
    logic             useRs;
    logic             useRt;
    logic             useRd;
    logic             loadUse;
    logic             loadEx;
    logic             haltPending;
    logic [CNT_W-1:0] drainCnt;
    logic [CNT_W-1:0] drainNext;

    // Control bundle per opcode, bit order as on ex_ctrl.
    always_comb begin
        idCtrl = 10'b0000000000;
        case (opcode)
            4'h0, 4'h1:       idCtrl = 10'b1000000111;
            4'h2:             idCtrl = 10'b1000000100;
            4'h3, 4'h7, 4'hE: idCtrl = 10'b1000000000;
            4'h4, 4'h5, 4'h6: idCtrl = 10'b1100000100;
            4'h8:             idCtrl = 10'b1011110000;
            4'h9:             idCtrl = 10'b0011011000;
            4'hA, 4'hB:       idCtrl = 10'b1001000000;
            default:          idCtrl = 10'b0000000000;
        endcase
    end

    // Which register fields the ID instruction actually reads; LLB/LHB read rd.
    always_comb begin
        useRs = (opcode <= 4'h9) || (opcode == 4'hD);
        useRt = (opcode <= 4'h3) || (opcode == 4'h7) || (opcode == 4'h9);
        useRd = (opcode == 4'hA) || (opcode == 4'hB);
    end

    // A load in EX (DstMux set) whose non-zero destination feeds ID forces one bubble.
    always_comb begin
        loadUse = LOAD_USE_EN && ex_valid && ex_ctrl[DST_BIT] && id_valid &&
                  (ex_rd != '0) &&
                  ((useRs && (ex_rd == id_rs)) ||
                   (useRt && (ex_rd == id_rt)) ||
                   (useRd && (ex_rd == id_rd)));
        loadEx   = !haltPending && !ext_stall && !flush && !loadUse;
        id_stall = haltPending | ext_stall | (loadUse & ~flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rd    <= '0;
        end else if (haltPending) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rd    <= '0;
        end else if (ext_stall) begin
            ex_valid <= ex_valid;
        end else if (flush || loadUse) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? idCtrl : '0;
            ex_rd    <= id_rd;
        end
    end

    assign drainNext = drainCnt + CNT_ONE;

    // halted rises on the edge that completes HLT_DRAIN non-stalled drain cycles;
    // with no drain required it rises on the first edge after haltPending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haltPending <= 1'b0;
            drainCnt    <= '0;
            halted      <= 1'b0;
        end else if (!haltPending) begin
            if (loadEx && id_valid && (opcode == OP_HLT)) begin
                haltPending <= 1'b1;
                drainCnt    <= '0;
            end
        end else if (!halted) begin
            if (drainCnt == DRAIN_TGT) begin
                halted <= 1'b1;
            end else if (!ext_stall) begin
                drainCnt <= drainNext;
                if (drainNext == DRAIN_TGT) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_ctrl_pipe
//
// Drives one id_ex_ctrl_pipe with the load-use stall enabled and a second copy
// with it disabled from the same inputs, and compares both against an
// instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_id_ex_ctrl_pipe;

    localparam int DRAIN = 3;

    logic       clk;
    logic       rst_n;
    logic       idValid;
    logic [3:0] opcode;
    logic [3:0] idRd;
    logic [3:0] idRs;
    logic [3:0] idRt;
    logic       extStall;
    logic       flush;

    logic       idStall,    idStallOff;
    logic       exValid,    exValidOff;
    logic [9:0] exCtrl,     exCtrlOff;
    logic [3:0] exRd,       exRdOff;
    logic       halted,     haltedOff;

    int vectors;
    int miscompares;
    logic stallSeen;
    logic stallSeenOff;

    // EX contents tracked as the instruction itself rather than control bits.
    typedef struct {
        bit       exValid;
        bit [3:0] exOp;
        bit [3:0] exRd;
        bit       haltPending;
        int       drained;
        bit       halted;
    } model_t;

    model_t mOn;
    model_t mOff;

    id_ex_ctrl_pipe #(.REG_W(4), .HLT_DRAIN(DRAIN), .LOAD_USE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .opcode(opcode),
        .id_rd(idRd), .id_rs(idRs), .id_rt(idRt), .ext_stall(extStall),
        .flush(flush), .id_stall(idStall), .ex_valid(exValid),
        .ex_ctrl(exCtrl), .ex_rd(exRd), .halted(halted)
    );

    id_ex_ctrl_pipe #(.REG_W(4), .HLT_DRAIN(DRAIN), .LOAD_USE_EN(1'b0)) dutNoLu (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .opcode(opcode),
        .id_rd(idRd), .id_rs(idRs), .id_rt(idRt), .ext_stall(extStall),
        .flush(flush), .id_stall(idStallOff), .ex_valid(exValidOff),
        .ex_ctrl(exCtrlOff), .ex_rd(exRdOff), .halted(haltedOff)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit [9:0] refCtrl(bit [3:0] op);
        bit wr  = (op <= 4'h8) || (op == 4'hA) || (op == 4'hB) || (op == 4'hE);
        bit alu = (op >= 4'h4) && (op <= 4'h6);
        bit mem = (op == 4'h8) || (op == 4'h9);
        bit rw  = (op == 4'h9);
        bit lb  = (op >= 4'h8) && (op <= 4'hB);
        bit dst = (op == 4'h8);
        bit z   = (op <= 4'h2) || ((op >= 4'h4) && (op <= 4'h6));
        bit vn  = (op <= 4'h1);
        return {wr, alu, mem, lb, dst, mem, rw, z, vn, vn};
    endfunction

    function automatic bit readsReg(bit [3:0] r);
        bit rsUsed = (opcode <= 4'h9) || (opcode == 4'hD);
        bit rtUsed = (opcode <= 4'h3) || (opcode == 4'h7) || (opcode == 4'h9);
        bit rdUsed = (opcode == 4'hA) || (opcode == 4'hB);
        return (rsUsed && idRs == r) || (rtUsed && idRt == r) || (rdUsed && idRd == r);
    endfunction

    function automatic bit refLoadUse(model_t m, bit en);
        return en && m.exValid && (m.exOp == 4'h8) && idValid && (m.exRd != 4'h0) &&
               readsReg(m.exRd);
    endfunction

    function automatic bit refStall(model_t m, bit en);
        return m.haltPending || extStall || (refLoadUse(m, en) && !flush);
    endfunction

    function automatic model_t refReset();
        model_t n;
        n.exValid = 0; n.exOp = 0; n.exRd = 0;
        n.haltPending = 0; n.drained = 0; n.halted = 0;
        return n;
    endfunction

    function automatic model_t refNext(model_t m, bit en);
        model_t n = m;
        if (m.haltPending) begin
            n.exValid = 0; n.exOp = 0; n.exRd = 0;
            n.drained = m.drained + (extStall ? 0 : 1);
            if (n.drained >= DRAIN) n.halted = 1;
        end else if (extStall) begin
            n = m;
        end else if (flush || refLoadUse(m, en)) begin
            n.exValid = 0; n.exOp = 0; n.exRd = 0;
        end else begin
            n.exValid = idValid;
            n.exOp    = opcode;
            n.exRd    = idRd;
            if (idValid && opcode == 4'hF) begin
                n.haltPending = 1;
                n.drained     = 0;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(string tag, logic [15:0] observed, logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkRegs();
        checkOutput("ex_valid",     exValid,    mOn.exValid);
        checkOutput("ex_ctrl",      exCtrl,     mOn.exValid ? refCtrl(mOn.exOp) : 10'd0);
        checkOutput("ex_rd",        exRd,       mOn.exRd);
        checkOutput("halted",       halted,     mOn.halted);
        checkOutput("ex_valid_off", exValidOff, mOff.exValid);
        checkOutput("ex_ctrl_off",  exCtrlOff,  mOff.exValid ? refCtrl(mOff.exOp) : 10'd0);
        checkOutput("ex_rd_off",    exRdOff,    mOff.exRd);
        checkOutput("halted_off",   haltedOff,  mOff.halted);
    endtask

    // One clock: check id_stall mid-cycle, advance the models on the edge,
    // then check the registered outputs just after it.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("id_stall",     idStall,    refStall(mOn, 1'b1));
        checkOutput("id_stall_off", idStallOff, refStall(mOff, 1'b0));
        stallSeen    = idStall;
        stallSeenOff = idStallOff;
        @(posedge clk);
        mOn  = refNext(mOn, 1'b1);
        mOff = refNext(mOff, 1'b0);
        #1;
        checkRegs();
    endtask

    task automatic setInstr(logic v, logic [3:0] op, logic [3:0] rd, logic [3:0] rs, logic [3:0] rt);
        idValid = v; opcode = op; idRd = rd; idRs = rs; idRt = rt;
    endtask

    initial begin
        int lat;
        bit seen;
        vectors = 0;
        miscompares = 0;
        stallSeen = 0;
        stallSeenOff = 0;
        rst_n = 1'b0;
        extStall = 1'b0;
        flush = 1'b0;
        setInstr(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        mOn  = refReset();
        mOff = refReset();

        #2;
        checkRegs();
        checkOutput("reset_id_stall", idStall, 1'b0);
        #6 rst_n = 1'b1;

        // ADD rd=3
        setInstr(1'b1, 4'h0, 4'h3, 4'h1, 4'h2);
        applyStimulus();
        checkOutput("plan_add_ctrl", exCtrl, 10'b1000000111);
        checkOutput("plan_add_rd", exRd, 4'h3);

        // LW rd=5 then SUB rs=5: one bubble, then SUB
        setInstr(1'b1, 4'h8, 4'h5, 4'h1, 4'h0);
        applyStimulus();
        setInstr(1'b1, 4'h1, 4'h6, 4'h5, 4'h2);
        applyStimulus();
        checkOutput("plan_lu_stall", stallSeen, 1'b1);
        checkOutput("plan_lu_bubble", exCtrl, 10'd0);
        checkOutput("plan_nolu_stall", stallSeenOff, 1'b0);
        applyStimulus();
        checkOutput("plan_lu_release", stallSeen, 1'b0);
        checkOutput("plan_sub_ctrl", exCtrl, 10'b1000000111);

        // LW rd=0 then ADD rs=0: no hazard
        setInstr(1'b1, 4'h8, 4'h0, 4'h1, 4'h0);
        applyStimulus();
        setInstr(1'b1, 4'h0, 4'h2, 4'h0, 4'h0);
        applyStimulus();
        checkOutput("plan_r0_nostall", stallSeen, 1'b0);

        // SW flushed in ID
        setInstr(1'b1, 4'h9, 4'h0, 4'h1, 4'h2);
        flush = 1'b1;
        applyStimulus();
        checkOutput("plan_sw_flush_ctrl", exCtrl, 10'd0);
        flush = 1'b0;

        // Flush coinciding with a load-use hazard
        setInstr(1'b1, 4'h8, 4'h5, 4'h1, 4'h0);
        applyStimulus();
        setInstr(1'b1, 4'h1, 4'h6, 4'h5, 4'h2);
        flush = 1'b1;
        applyStimulus();
        checkOutput("plan_flush_wins", stallSeen, 1'b0);
        flush = 1'b0;

        // XOR held in EX by ext_stall for three cycles
        setInstr(1'b1, 4'h2, 4'h7, 4'h1, 4'h2);
        applyStimulus();
        setInstr(1'b1, 4'h0, 4'h1, 4'h2, 4'h3);
        extStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("plan_xor_hold", exCtrl, 10'b1000000100);
            checkOutput("plan_xor_stall", stallSeen, 1'b1);
        end
        extStall = 1'b0;

        // Randomized traffic, HLT excluded; ID is held while stalled
        for (int i = 0; i < 400; i++) begin
            if (!stallSeen) begin
                setInstr($urandom_range(0, 9) != 0, 4'($urandom_range(0, 14)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)));
            end
            extStall = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            applyStimulus();
        end

        // HLT with one ext_stall cycle during the drain
        extStall = 1'b0;
        flush = 1'b0;
        setInstr(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus();
        setInstr(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        applyStimulus();
        checkOutput("plan_hlt_valid", exValid, 1'b1);
        checkOutput("plan_hlt_ctrl", exCtrl, 10'd0);
        lat = 0;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            setInstr(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
            extStall = (k == 2);
            applyStimulus();
            if (halted === 1'b1) begin
                seen = 1;
                lat = k;
            end
        end
        extStall = 1'b0;
        checkOutput("plan_halt_latency", 16'(lat), 16'd4);

        for (int i = 0; i < 5; i++) begin
            setInstr(1'b1, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            flush = $urandom_range(0, 1) == 1;
            applyStimulus();
            checkOutput("plan_halt_sticky", halted, 1'b1);
        end
        flush = 1'b0;

        // Asynchronous reset clears the halt without a clock edge
        #2 rst_n = 1'b0;
        #1;
        mOn  = refReset();
        mOff = refReset();
        checkOutput("plan_async_halted", halted, 1'b0);
        checkOutput("plan_async_halted_off", haltedOff, 1'b0);
        checkRegs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        setInstr(1'b1, 4'h0, 4'h3, 4'h1, 4'h2);
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_pipe.md
Name: id_ex_ctrl_pipe

Overview:
- Sequential successor to the single-cycle opcode decoder.
- Decodes the 4-bit WISC opcode in ID, registers the control bundle into the ID/EX pipeline register with a valid bit, and detects load-use hazards.
- Handles stall and flush, and sequences HLT drain to a sticky halted flag.
- Sits between the IF/ID register and the EX stage; id_stall freezes PC and IF/ID.

Parameters:
- REG_W, 4, register-address width.
- HLT_DRAIN, 3, non-stalled cycles after HLT enters EX before halted asserts (pipeline drain).
- LOAD_USE_EN, 1, 1 enables load-use hazard stall; 0 forces that stall term to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- opcode  in  4  instr[15:12].
- id_rd  in  REG_W  destination field.
- id_rs  in  REG_W  source-1 field.
- id_rt  in  REG_W  source-2 field.
- ext_stall  in  1  downstream (memory) busy; freeze EX register.
- flush  in  1  taken branch; squash ID.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  10  {WriteReg, ALU2Mux, addrCalc, loadByteMux, DstMux, enableMem, readWriteMem, Zen, Ven, Nen}, bit 9 = WriteReg.
- ex_rd  out  REG_W  registered destination.
- halted  out  1  sticky halt.

Behaviour:
Decode (combinational, ID):
- WriteReg = 1 for opcodes 0x0-0x8, 0xA, 0xB, 0xE.
- ALU2Mux = 1 for 0x4-0x6.
- addrCalc = enableMem = 1 for 0x8, 0x9.
- readWriteMem = 1 for 0x9.
- loadByteMux = 1 for 0x8-0xB.
- DstMux = 1 for 0x8.
- Zen = 1 for 0x0, 0x1, 0x2, 0x4, 0x5, 0x6.
- Ven = Nen = 1 for 0x0, 0x1.

Source usage:
- rs is used by 0x0-0x9 and 0xD.
- rt is used by 0x0-0x3, 0x7, 0x9.
- rd is read by 0xA and 0xB.

Reset (async, rst_n=0):
- ex_valid=0, ex_ctrl=0, ex_rd=0, halted=0, halt_pending=0, drain counter=0.
- id_stall then follows its combinational equation.
- Reset mid-drain aborts the halt.

Bubble: ex_valid=0, ex_ctrl=0, ex_rd=0.

EX register update, priority highest first, each rising edge:
1. halt_pending=1: load bubble; flush ignored.
2. ext_stall=1: hold all EX contents.
3. flush=1: load bubble.
4. load_use=1: load bubble; ID held.
5. Otherwise: load ex_valid=id_valid and decoded ctrl gated by id_valid (0 when id_valid=0); ex_rd=id_rd.

Load-use hazard:
- load_use = LOAD_USE_EN & ex_valid & ex_ctrl.DstMux & id_valid & (ex_rd != 0) & (ex_rd matches any used source of the ID opcode).
- Inserts exactly one bubble. On the next cycle the LW has left EX, so ID proceeds.

id_stall = halt_pending | ext_stall | (load_use & ~flush).

HLT sequencing:
- When opcode 0xF is loaded into EX (valid, not flushed), halt_pending sets on that edge.
- Drain counter increments each cycle with halt_pending=1 and ext_stall=0.
- When the counter reaches HLT_DRAIN, halted=1; it stays 1 until reset.
- With HLT_DRAIN=0, halted rises one cycle after halt_pending.
- HLT writes no register and enables no flags (ex_ctrl=0, ex_valid=1 for its one EX cycle).

Simultaneous events:
- flush with load_use: flush wins and id_stall=0.
- ext_stall with load_use: EX held; hazard is re-evaluated next cycle.

Test Plan:
- Reset, then ADD (0x0, rd=3): after 1 edge ex_valid=1, ex_ctrl=10'b1000000111, ex_rd=3.
- LW rd=5, then SUB rs=5: id_stall=1 for exactly 1 cycle; EX shows bubble (ctrl=0), then SUB with ctrl=10'b1000000111.
- LW rd=0, then ADD rs=0: no stall. Repeat the LW rd=5 case with LOAD_USE_EN=0: no stall.
- SW (0x9) in ID with flush=1: EX gets bubble, no memory enable. Flush with load_use pending: id_stall=0.
- ext_stall=1 for 3 cycles with XOR in EX: ex_ctrl stays 10'b1000000100 and id_stall=1 throughout.
- HLT issued, HLT_DRAIN=3, one ext_stall cycle during drain: halted rises 4 cycles after HLT enters EX; later id_valid or flush have no effect; rst_n low clears halted asynchronously.
